tl_sensor_cond: RTL and testbench

- Conditions the raw roadside inputs for the `trafficlight` controller and sits directly upstream of it.
- Synchronizes and debounces the East-West vehicle sensor and the emergency-vehicle sensor.
- Stretches the emergency request and flags a stuck EW sensor.
- Counts EW arrivals for status readout.
- `ew_sensor` and `emgcy_sensor` connect by name to the `trafficlight` inputs of the same names.

---
 rtl/tl_pkg.sv | 21 ++
 rtl/tl_debounce.sv | 62 ++++++
 rtl/tl_sensor_cond.sv | 97 +++++++++
 tb/tb_tl_sensor_cond.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_pkg : types and default timing shared by the traffic-light blocks |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package tl_pkg;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    RED       = 3'd1,
    YELLOW    = 3'd2,
    GREEN     = 3'd3,
    PRE_GREEN = 3'd4
  } lights_t;

  localparam int TL_DEB_CYCLES   = 4;
  localparam int TL_EMGCY_HOLD   = 16;
  localparam int TL_STUCK_CYCLES = 64;

endpackage
`default_nettype wire

// File: rtl/tl_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_debounce : 2-flop synchronizer followed by a counting debouncer   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tl_debounce
  import tl_pkg::*;
#(
  parameter int DEB_CYCLES = TL_DEB_CYCLES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_differs;
  logic          w_update;

  assign w_cnt_inc = r_cnt + 1'b1;
  assign w_differs = (r_sync2 != r_stable);
  assign w_update  = w_differs && (w_cnt_inc == CW'(DEB_CYCLES));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= raw;
      r_sync2 <= r_sync1;
      if (w_differs) begin
        if (w_update) begin
          r_stable <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= w_cnt_inc;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  // rise/fall flag the edge on which clean is about to change, so
  // downstream logic can react on the same edge as the new value lands.
  assign clean = r_stable;
  assign rise  = w_update &  r_sync2;
  assign fall  = w_update & ~r_sync2;

endmodule
`default_nettype wire

// File: rtl/tl_sensor_cond.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tl_sensor_cond : debounce, emergency stretch, stuck flag, car count  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tl_sensor_cond
  import tl_pkg::*;
#(
  parameter int DEB_CYCLES   = TL_DEB_CYCLES,
  parameter int EMGCY_HOLD   = TL_EMGCY_HOLD,
  parameter int STUCK_CYCLES = TL_STUCK_CYCLES,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             ew_sensor_raw,
  input  logic             emgcy_raw,
  input  logic             cnt_clr,
  output logic             ew_sensor,
  output logic             emgcy_sensor,
  output logic             ew_stuck,
  output logic [CNT_W-1:0] ew_car_cnt
);

  localparam int HW = $clog2(EMGCY_HOLD + 1);
  localparam int SW = $clog2(STUCK_CYCLES + 1);

  logic             w_ew_clean, w_ew_rise, w_ew_fall;
  logic             w_emg_clean, w_emg_rise, w_emg_fall;
  logic [HW-1:0]    r_hold;
  logic [SW-1:0]    r_stuck_cnt;
  logic             r_ew_rise_d;
  logic [CNT_W-1:0] r_car_cnt;

  tl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_ew (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (ew_sensor_raw),
    .clean   (w_ew_clean),
    .rise    (w_ew_rise),
    .fall    (w_ew_fall)
  );

  tl_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_emg (
    .clk     (clk),
    .reset_n (reset_n),
    .raw     (emgcy_raw),
    .clean   (w_emg_clean),
    .rise    (w_emg_rise),
    .fall    (w_emg_fall)
  );

  // Hold loads on the same edge the debounced value drops, so the OR below
  // never dips low between the two terms.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold <= '0;
    end else if (w_emg_fall) begin
      r_hold <= HW'(EMGCY_HOLD);
    end else if (w_emg_rise) begin
      r_hold <= '0;
    end else if (r_hold != '0) begin
      r_hold <= r_hold - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stuck_cnt <= '0;
    end else if (!w_ew_clean || w_ew_fall) begin
      r_stuck_cnt <= '0;
    end else if (r_stuck_cnt != SW'(STUCK_CYCLES)) begin
      r_stuck_cnt <= r_stuck_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_ew_rise_d <= 1'b0;
      r_car_cnt   <= '0;
    end else begin
      r_ew_rise_d <= w_ew_rise;
      if (cnt_clr) begin
        r_car_cnt <= r_ew_rise_d ? CNT_W'(1) : '0;
      end else if (r_ew_rise_d) begin
        r_car_cnt <= r_car_cnt + 1'b1;
      end
    end
  end

  assign ew_sensor    = w_ew_clean;
  assign emgcy_sensor = w_emg_clean | (r_hold != '0);
  assign ew_stuck     = (r_stuck_cnt == SW'(STUCK_CYCLES));
  assign ew_car_cnt   = r_car_cnt;

endmodule
`default_nettype wire

// File: tb/tb_tl_sensor_cond.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_tl_sensor_cond : scoreboard bench for tl_sensor_cond              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_tl_sensor_cond;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       ew_raw, emg_raw, cnt_clr;
  logic       ew_sensor, emgcy_sensor, ew_stuck;
  logic [7:0] ew_car_cnt;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  typedef struct {
    int at;
    int sig;
    int val;
  } exp_t;
  exp_t sb[$];

  string names[4] = '{"ew_sensor", "emgcy_sensor", "ew_stuck", "ew_car_cnt"};

  tl_sensor_cond #(
    .DEB_CYCLES   (4),
    .EMGCY_HOLD   (16),
    .STUCK_CYCLES (64),
    .CNT_W        (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ew_sensor_raw (ew_raw),
    .emgcy_raw     (emg_raw),
    .cnt_clr       (cnt_clr),
    .ew_sensor     (ew_sensor),
    .emgcy_sensor  (emgcy_sensor),
    .ew_stuck      (ew_stuck),
    .ew_car_cnt    (ew_car_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic int actual(int sig);
    case (sig)
      0:       return int'(ew_sensor);
      1:       return int'(emgcy_sensor);
      2:       return int'(ew_stuck);
      default: return int'(ew_car_cnt);
    endcase
  endfunction

  task automatic check(string name, int act, int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s edge=%0d actual=%0d required=%0d", name, edge_cnt, act, req);
    end
  endtask

  task automatic chk_all0(string tag);
    check({tag, ":ew_sensor"},    actual(0), 0);
    check({tag, ":emgcy_sensor"}, actual(1), 0);
    check({tag, ":ew_stuck"},     actual(2), 0);
    check({tag, ":ew_car_cnt"},   actual(3), 0);
  endtask

  task automatic push(int sig, int from, int to, int val);
    for (int e = from; e <= to; e++) sb.push_back('{e, sig, val});
  endtask

  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: after every edge, retire all expectations due at this edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].at == edge_cnt) begin
          check(names[sb[i].sig], actual(sb[i].sig), sb[i].val);
          sb.delete(i);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog edge=%0d actual=timeout required=finish", edge_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0;
    reset_n = 1'b0;
    ew_raw  = 1'b0;
    emg_raw = 1'b0;
    cnt_clr = 1'b0;

    // Reset held with raw inputs toggling
    #1;
    chk_all0("reset_t0");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      ew_raw  = ~ew_raw;
      emg_raw = (i % 2 == 0);
      #2;
      chk_all0("reset_hold");
    end
    @(negedge clk);
    ew_raw  = 1'b0;
    emg_raw = 1'b0;
    reset_n = 1'b1;
    cyc(3);

    // Clean EW arrival
    e0 = edge_cnt;
    ew_raw = 1'b1;
    push(0, e0 + 1,  e0 + 5,  0);
    push(0, e0 + 6,  e0 + 25, 1);
    push(0, e0 + 26, e0 + 30, 0);
    push(3, e0 + 1,  e0 + 6,  0);
    push(3, e0 + 7,  e0 + 30, 1);
    push(2, e0 + 1,  e0 + 30, 0);
    cyc(20);
    ew_raw = 1'b0;
    cyc(12);

    // Clear counter, then a 3-cycle glitch must be rejected
    e0 = edge_cnt;
    cnt_clr = 1'b1;
    push(3, e0 + 1, e0 + 16, 0);
    cyc(1);
    cnt_clr = 1'b0;
    e0 = edge_cnt;
    ew_raw = 1'b1;
    push(0, e0 + 1, e0 + 15, 0);
    cyc(3);
    ew_raw = 1'b0;
    cyc(16);

    // Emergency stretch
    e0 = edge_cnt;
    emg_raw = 1'b1;
    push(1, e0 + 1,  e0 + 5,  0);
    push(1, e0 + 6,  e0 + 31, 1);
    push(1, e0 + 32, e0 + 40, 0);
    cyc(10);
    emg_raw = 1'b0;
    cyc(32);

    // Re-pulse inside the hold window: no low gap
    e0 = edge_cnt;
    emg_raw = 1'b1;
    push(1, e0 + 1,  e0 + 5,  0);
    push(1, e0 + 6,  e0 + 53, 1);
    push(1, e0 + 54, e0 + 58, 0);
    cyc(10);
    emg_raw = 1'b0;
    cyc(12);
    emg_raw = 1'b1;
    cyc(10);
    emg_raw = 1'b0;
    cyc(30);

    // Stuck EW sensor
    e0 = edge_cnt;
    ew_raw = 1'b1;
    push(0, e0 + 1,  e0 + 5,  0);
    push(0, e0 + 6,  e0 + 85, 1);
    push(0, e0 + 86, e0 + 90, 0);
    push(2, e0 + 1,  e0 + 69, 0);
    push(2, e0 + 70, e0 + 85, 1);
    push(2, e0 + 86, e0 + 90, 0);
    push(3, e0 + 6,  e0 + 6,  0);
    push(3, e0 + 7,  e0 + 90, 1);
    cyc(80);
    ew_raw = 1'b0;
    cyc(14);

    // 256 clean pulses wrap the counter back to 0
    e0 = edge_cnt;
    cnt_clr = 1'b1;
    push(3, e0 + 1, e0 + 1, 0);
    cyc(1);
    cnt_clr = 1'b0;
    for (int p = 0; p < 256; p++) begin
      ew_raw = 1'b1;
      cyc(8);
      ew_raw = 1'b0;
      cyc(8);
      if (p == 127) push(3, edge_cnt + 1, edge_cnt + 1, 128);
      if (p == 254) push(3, edge_cnt + 1, edge_cnt + 1, 255);
    end
    push(3, edge_cnt + 1, edge_cnt + 3, 0);
    cyc(4);

    // cnt_clr coincident with an increment yields 1
    for (int p = 0; p < 2; p++) begin
      ew_raw = 1'b1;
      cyc(8);
      ew_raw = 1'b0;
      cyc(8);
    end
    e0 = edge_cnt;
    ew_raw = 1'b1;
    push(3, e0 + 1, e0 + 6,  2);
    push(3, e0 + 7, e0 + 10, 1);
    cyc(6);
    cnt_clr = 1'b1;
    cyc(1);
    cnt_clr = 1'b0;
    ew_raw  = 1'b0;
    cyc(12);

    // Asynchronous reset in the middle of the emergency hold
    e0 = edge_cnt;
    emg_raw = 1'b1;
    push(1, e0 + 6, e0 + 20, 1);
    cyc(10);
    emg_raw = 1'b0;
    cyc(11);
    #2;
    check("emgcy_hold_pre_reset", actual(1), 1);
    reset_n = 1'b0;
    #1;
    check("emgcy_async_drop", actual(1), 0);
    chk_all0("midhold_reset");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #2;
      chk_all0("midhold_reset_hold");
    end
    @(negedge clk);
    reset_n = 1'b1;
    push(1, edge_cnt + 1, edge_cnt + 20, 0);
    push(3, edge_cnt + 1, edge_cnt + 20, 0);
    cyc(22);

    foreach (sb[i]) begin
      bad++;
      $display("FAIL unchecked_%s edge=%0d actual=none required=%0d", names[sb[i].sig], sb[i].at, sb[i].val);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
